// File: rtl/chan_scan_selector_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : chan_scan_selector_if                                    |
// | Description : Source/consumer bundle for the channel scan selector:    |
// |               flattened channel inputs, mode and load/hold controls,   |
// |               and the registered data and status outputs.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface chan_scan_selector_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic                      mode;
    logic [SEL_W-1:0]          ctrl;
    logic                      load;
    logic                      hold;
    logic [WIDTH-1:0]          out;
    logic [SEL_W-1:0]          sel;
    logic                      chg;
    logic                      wrap;
    logic                      err;

    // Side that supplies samples and controls, and consumes the selection
    modport master (
        output in_bus, mode, ctrl, load, hold,
        input  out, sel, chg, wrap, err
    );

    // The selector itself
    modport slave (
        input  in_bus, mode, ctrl, load, hold,
        output out, sel, chg, wrap, err
    );
endinterface
`default_nettype wire

// File: rtl/chan_scan_selector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : chan_scan_selector                                       |
// | Description : Registered N-channel data selector with manual (load)    |
// |               and auto-scan modes, hold, out-of-range detection and    |
// |               channel-change / wrap strobes.                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module chan_scan_selector #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    chan_scan_selector_if.slave  bus
);

    // Dwell counter only ever reaches DWELL-1, but is sized for DWELL itself
    localparam int          CNT_W   = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [31:0] CH_U    = 32'(CHANNELS);
    localparam logic [31:0] CH_LAST = 32'(CHANNELS - 1);
    localparam logic [31:0] DW_LAST = 32'(DWELL - 1);

    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_d;
    logic             mode_d;

    logic [WIDTH-1:0] chan [CHANNELS];
    logic [31:0]      sel_u;
    logic             in_range;
    logic [WIDTH-1:0] pick;
    logic             dwell_end;
    logic [SEL_W-1:0] scan_next;
    logic             scan_wrap;

    // Unpack the flattened input bus into per-channel words
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan[k] = bus.in_bus[k*WIDTH +: WIDTH];
    end

    // Channel mux by equality so an out-of-range index naturally yields zero
    always_comb begin
        sel_u    = 32'(bus.sel);
        in_range = (sel_u < CH_U);
        pick     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_u == 32'(k)) begin
                pick = chan[k];
            end
        end
    end

    // Next index on a scan advance; only the CHANNELS-1 -> 0 step is a wrap
    always_comb begin
        dwell_end = (32'(cnt) == DW_LAST);
        scan_wrap = 1'b0;
        if (sel_u == CH_LAST) begin
            scan_next = '0;
            scan_wrap = 1'b1;
        end else if (!in_range) begin
            scan_next = '0;
        end else begin
            scan_next = bus.sel + SEL_W'(1);
        end
    end

    // Index / dwell state and the registered data path.
    // mode_d follows mode during reset so that leaving reset in scan mode
    // is not mistaken for a mode transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sel  <= '0;
            cnt      <= '0;
            bus.out  <= '0;
            bus.chg  <= 1'b0;
            bus.wrap <= 1'b0;
            bus.err  <= 1'b0;
            sel_d    <= '0;
            mode_d   <= bus.mode;
        end else if (bus.hold) begin
            bus.chg  <= 1'b0;
            bus.wrap <= 1'b0;
        end else begin
            bus.out  <= pick;
            bus.err  <= !in_range;
            bus.chg  <= (bus.sel != sel_d);
            sel_d    <= bus.sel;
            mode_d   <= bus.mode;
            bus.wrap <= 1'b0;
            if (bus.load) begin
                bus.sel <= bus.ctrl;
                cnt     <= '0;
            end else if (bus.mode != mode_d) begin
                // A mode change restarts the dwell and swallows any advance
                cnt <= '0;
            end else if (bus.mode) begin
                if (dwell_end) begin
                    cnt      <= '0;
                    bus.sel  <= scan_next;
                    bus.wrap <= scan_wrap;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chan_scan_selector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_chan_scan_selector                                    |
// | Description : Directed self-checking bench for chan_scan_selector.     |
// |               Three instances: 8ch/dwell 4, 5ch/dwell 3, 8ch/dwell 3.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_chan_scan_selector;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_checks;
    int   n_fail;
    int   chg_cnt;
    int   wrap_cnt;

    chan_scan_selector_if #(.WIDTH(4), .CHANNELS(8), .SEL_W(3)) ia ();
    chan_scan_selector_if #(.WIDTH(4), .CHANNELS(5), .SEL_W(3)) ib ();
    chan_scan_selector_if #(.WIDTH(4), .CHANNELS(8), .SEL_W(3)) ic ();

    chan_scan_selector #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (ia)
    );
    chan_scan_selector #(.WIDTH(4), .CHANNELS(5), .SEL_W(3), .DWELL(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (ib)
    );
    chan_scan_selector #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(3)) dut_c (
        .clk   (clk),
        .rst_n (rst_c),
        .bus   (ic)
    );

    // Free-running clock, 10 time units
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] pattern8();
        logic [31:0] v;
        for (int k = 0; k < 8; k++) v[k*4 +: 4] = 4'(k + 5);
        return v;
    endfunction

    function automatic logic [19:0] pattern5();
        logic [19:0] v;
        for (int k = 0; k < 5; k++) v[k*4 +: 4] = 4'(k + 5);
        return v;
    endfunction

    initial begin
        logic [31:0] p8;
        n_checks = 0;
        n_fail   = 0;
        chg_cnt  = 0;
        wrap_cnt = 0;
        p8       = pattern8();

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ia.in_bus = 32'($urandom); ia.mode = 1'b0; ia.ctrl = '0; ia.load = 1'b0; ia.hold = 1'b0;
        ib.in_bus = pattern5();    ib.mode = 1'b0; ib.ctrl = '0; ib.load = 1'b0; ib.hold = 1'b0;
        ic.in_bus = p8;            ic.mode = 1'b1; ic.ctrl = '0; ic.load = 1'b0; ic.hold = 1'b0;

        // ---------------- reset ----------------
        tick(2);
        check("rst_out",  ia.out,  0);
        check("rst_sel",  ia.sel,  0);
        check("rst_chg",  ia.chg,  0);
        check("rst_wrap", ia.wrap, 0);
        check("rst_err",  ia.err,  0);

        ia.in_bus = p8;
        rst_a = 1'b1;
        tick(1);
        check("rel_out", ia.out, 5);
        check("rel_chg", ia.chg, 0);

        // ---------------- manual select ----------------
        ia.ctrl = 3'd6; ia.load = 1'b1;
        tick(1);
        ia.load = 1'b0;
        check("man_sel", ia.sel, 6);
        tick(1);
        check("man_out", ia.out, 4'hB);
        check("man_chg1", ia.chg, 1);
        tick(1);
        check("man_chg0", ia.chg, 0);

        // Data latency on the selected channel
        ia.in_bus[6*4 +: 4] = 4'h3;
        tick(1);
        check("lat_out", ia.out, 4'h3);
        ia.in_bus = p8;

        // ---------------- auto-scan sweep ----------------
        rst_a = 1'b0; ia.mode = 1'b1;
        tick(2);
        rst_a = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            tick(1);
            check("sweep_sel",  ia.sel,  32'((n / 4) % 8));
            check("sweep_out",  ia.out,  32'(((n - 1) / 4) % 8 + 5));
            check("sweep_wrap", ia.wrap, 32'((n % 32) == 0));
            if (ia.chg)  chg_cnt++;
            if (ia.wrap) wrap_cnt++;
        end
        check("sweep_nchg",  chg_cnt,  15);
        check("sweep_nwrap", wrap_cnt, 2);

        // ---------------- hold beats load ----------------
        tick(14);
        check("pre_hold_sel", ia.sel, 3);
        ia.hold = 1'b1; ia.load = 1'b1; ia.ctrl = 3'd1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("hold_sel",  ia.sel,  3);
            check("hold_out",  ia.out,  8);
            check("hold_chg",  ia.chg,  0);
            check("hold_wrap", ia.wrap, 0);
        end
        ia.hold = 1'b0; ia.load = 1'b0;
        tick(1);
        check("rel_hold_sel1", ia.sel, 3);
        tick(1);
        check("rel_hold_sel2", ia.sel, 4);

        // Load during scan resumes from the loaded index
        ia.ctrl = 3'd6; ia.load = 1'b1;
        tick(1);
        ia.load = 1'b0;
        check("scan_load_sel", ia.sel, 6);
        tick(3);
        check("scan_load_dw", ia.sel, 6);
        tick(1);
        check("scan_load_adv", ia.sel, 7);

        // Back to manual: index stays put
        ia.mode = 1'b0;
        tick(5);
        check("man_again_sel", ia.sel, 7);
        check("man_again_out", ia.out, 4'hC);

        // ---------------- non-power-of-two, out of range ----------------
        rst_b = 1'b1;
        tick(1);
        ib.ctrl = 3'd6; ib.load = 1'b1;
        tick(1);
        ib.load = 1'b0;
        check("np2_sel", ib.sel, 6);
        tick(1);
        check("np2_err", ib.err, 1);
        check("np2_out", ib.out, 0);
        ib.mode = 1'b1;
        tick(1);
        check("np2_mode_sel", ib.sel, 6);
        tick(2);
        check("np2_dw_sel", ib.sel, 6);
        tick(1);
        check("np2_adv_sel",  ib.sel,  0);
        check("np2_adv_wrap", ib.wrap, 0);
        tick(1);
        check("np2_err0", ib.err, 0);
        check("np2_out0", ib.out, 5);
        check("np2_chg",  ib.chg, 1);

        // ---------------- reset mid-scan ----------------
        rst_c = 1'b1;
        tick(15);
        check("mid_pre_sel", ic.sel, 5);
        rst_c = 1'b0; ic.hold = 1'b1; ic.load = 1'b1; ic.ctrl = 3'd4;
        tick(1);
        check("mid_rst_sel", ic.sel, 0);
        check("mid_rst_out", ic.out, 0);
        rst_c = 1'b1; ic.hold = 1'b0; ic.load = 1'b0;
        tick(2);
        check("mid_dw_sel", ic.sel, 0);
        tick(1);
        check("mid_adv_sel", ic.sel, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chan_scan_selector.md
# chan_scan_selector

Parametrised, registered N-channel data selector, the successor to the team's fixed 8-to-1, 4-bit combinational selector. It supports two modes. In manual mode, a strobed channel index picks the input. In auto-scan mode, the block steps through every channel with a programmable dwell time. It also provides hold, out-of-range detection and channel-change/wrap strobes. It sits between a bank of parallel sample sources and a single downstream consumer, for example a display, UART or analysis logic.

## Interface
- `WIDTH`, default 4: bits per channel.
- `CHANNELS`, default 8: number of inputs, 2..256. It need not be a power of two.
- `SEL_W`, default 3: index width. Must equal ceil(log2(CHANNELS)) and be at least 1.
- `DWELL`, default 4: clocks spent on each channel in scan mode, 1..65535.
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `in_bus`, in, CHANNELS*WIDTH: flattened inputs. Channel k occupies bits [k*WIDTH +: WIDTH].
- `mode`, in, 1: 0 = manual, 1 = auto-scan.
- `ctrl`, in, SEL_W: requested channel index, used only when `load` is high.
- `load`, in, 1: one-cycle strobe that latches `ctrl` into `sel`.
- `hold`, in, 1: freezes `sel`, the dwell counter and `out` while high.
- `out`, out, WIDTH: registered data from the selected channel.
- `sel`, out, SEL_W: the current channel index register.
- `chg`, out, 1: one-cycle pulse in the cycle where `out` first shows a newly selected channel.
- `wrap`, out, 1: one-cycle pulse when scan advances from CHANNELS-1 to 0.
- `err`, out, 1: high while `sel` is at or above CHANNELS.

## Operation
- **Registers.**
  - `sel`: SEL_W bits.
  - `cnt`: dwell counter, ceil(log2(DWELL+1)) bits, minimum 1.
  - `out`, `chg`, `wrap`, `err`.
  - `sel_d`: previous `sel`, used to generate `chg`.
- **Priority per cycle** (highest first): reset, `hold`, `load`, scan advance.
- **Hold.** All registers keep their values. `chg` and `wrap` are forced to 0.
- **Load.** `sel <= ctrl` and `cnt <= 0`. Load is accepted in both modes. In scan mode, scanning resumes from the loaded index.
- **Manual mode.** `sel` changes only on `load`, and `cnt` stays at 0.
- **Scan mode.**
  - `cnt` increments every cycle.
  - When `cnt == DWELL-1`, `cnt <= 0` and `sel` advances.
  - Advance: `sel <= sel+1`. If `sel == CHANNELS-1`, `sel <= 0` and `wrap` pulses in the same cycle that `sel` updates.
  - An out-of-range `sel` (at or above CHANNELS) advances to 0, with no `wrap` pulse.
- **Mode transitions.** A change of `mode` in either direction clears `cnt` on that edge and leaves `sel` unchanged. If a scan advance would coincide with the change, it is suppressed.
- **Data path.**
  - `out <= in_bus[sel]` every cycle that is not held.
  - If `sel` is at or above CHANNELS, `out <= 0`. The output is never X, and `err` mirrors the condition, registered alongside `out`.
- **Change strobe.** `chg <= (sel != sel_d)`, registered alongside `out`, so it marks the first cycle of valid new-channel data.
- **Width rules.**
  - Index comparisons are unsigned.
  - `ctrl` values at or above CHANNELS are accepted into `sel`; they only raise `err`.
  - With DWELL=1, scan mode advances every cycle.

## Timing
- **Reset values.** While `rst_n` is low at a clock edge: `sel=0`, `cnt=0`, `out=0`, `chg=0`, `wrap=0`, `err=0`, `sel_d=0`.
- **Load latency.**
  - Load sampled at edge k gives `sel` = new value after edge k.
  - `out` = new channel data and `chg=1` after edge k+1.
  - `chg` returns to 0 after edge k+2 unless `sel` changes again.
- **Data latency.** A change on `in_bus` of the selected channel appears on `out` one clock later.
- **Scan period.**
  - Each channel's data is on `out` for exactly DWELL cycles.
  - A full sweep takes CHANNELS*DWELL cycles.
  - `wrap` and the resulting `chg` are one cycle apart: `wrap` comes with the `sel` update, `chg` one cycle later.
- **Hold.** Raising `hold` at edge k freezes state from edge k onward. Releasing it resumes counting from the frozen `cnt`, and no cycles are lost or added.
- **Reset mid-scan.** Reset returns the block to channel 0 with `cnt=0` on the next edge, regardless of `hold` or `load`.

## Test plan
- **Reset.** Drive `rst_n=0` for 2 clocks with random `in_bus` -> all outputs 0. After release in manual mode, `out` = channel 0 data from the next edge, with `chg=0`.
- **Manual select.** CHANNELS=8, WIDTH=4, each channel k driven to k+5. Load `ctrl=6` -> `sel=6` after 1 clock, `out=4'hB` and `chg=1` after 2 clocks, `chg=0` after 3 clocks.
- **Auto-scan sweep.** DWELL=4, `mode=1` from reset -> `sel` sequence 0..7 with each value held 4 cycles. `wrap` pulses once every 32 cycles on the 7 -> 0 transition. `chg` produces 8 pulses per sweep.
- **Hold and load priority.** During scan at `sel=3`, `cnt=2`, assert `hold` for 5 cycles together with `load`/`ctrl=1` -> `sel` stays 3 and `cnt` stays 2. After release, `sel` advances to 4 exactly 2 cycles later.
- **Non-power-of-two.** CHANNELS=5, SEL_W=3. Load `ctrl=6` -> `err=1`, `out=0`. Switching to scan then gives `sel=0` after DWELL cycles, with `err=0` and no `wrap`.
- **Reset mid-operation.** Assert `rst_n=0` for one cycle at `sel=5` during scan with DWELL=3 -> `sel=0` and `cnt=0`. The first advance to 1 follows 3 cycles after release.
